// File: rtl/weight_comp_collector.sv
// weight_comp_collector: gathers reduced weights plus per-column compensation entries,
// then streams one column beat at a time over a valid/ready handshake.
module weight_comp_collector #(
    parameter int SIZE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wt_valid,
    input  logic [5:0]  wt_addr,
    input  logic [4:0]  reduced_wt,
    input  logic        comp_valid,
    input  logic [2:0]  comp_row,
    input  logic [2:0]  comp_wt,
    input  logic        load_done,
    input  logic        start,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [2:0]  out_col,
    output logic [39:0] out_wts,
    output logic [20:0] out_comp,
    output logic        ready_flag,
    output logic        overflow
);
    typedef enum logic [1:0] {LOAD, READY, STREAM} state_t;
    state_t     r_state;
    logic [2:0] r_col;
    logic [4:0] r_store [SIZE*SIZE];
    logic [6:0] r_slot [SIZE][3];
    logic [1:0] r_cnt [SIZE];
    logic       r_ovf;
    logic [2:0] w_wcol;
    logic       w_stream;
    assign w_wcol   = wt_addr[5:3];
    assign w_stream = (r_state == STREAM);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
            r_col   <= '0;
            r_ovf   <= 1'b0;
            for (int a = 0; a < SIZE*SIZE; a++) r_store[a] <= '0;
            for (int c = 0; c < SIZE; c++) begin
                r_cnt[c] <= '0;
                for (int s = 0; s < 3; s++) r_slot[c][s] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (wt_valid) begin
                        r_store[wt_addr] <= reduced_wt;
                        if (comp_valid) begin
                            if (r_cnt[w_wcol] != 2'd3) begin
                                r_slot[w_wcol][r_cnt[w_wcol]] <= {1'b1, comp_row, comp_wt};
                                r_cnt[w_wcol] <= r_cnt[w_wcol] + 2'd1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                    if (load_done) r_state <= READY;
                end
                READY: begin
                    if (start) begin
                        r_state <= STREAM;
                        r_col   <= '0;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (r_col == 3'd7) begin
                            // Store survives; only the compensation table is emptied for the next load.
                            r_state <= LOAD;
                            r_col   <= '0;
                            for (int c = 0; c < SIZE; c++) begin
                                r_cnt[c] <= '0;
                                for (int s = 0; s < 3; s++) r_slot[c][s] <= '0;
                            end
                        end else begin
                            r_col <= r_col + 3'd1;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end
    assign out_valid  = w_stream;
    assign out_col    = w_stream ? r_col : 3'd0;
    assign ready_flag = (r_state == READY);
    assign overflow   = r_ovf;
    for (genvar r = 0; r < SIZE; r++) begin : g_row
        assign out_wts[5*r +: 5] = w_stream ? r_store[{r_col, 3'(r)}] : 5'd0;
    end
    for (genvar s = 0; s < 3; s++) begin : g_slot
        assign out_comp[7*s +: 7] = (w_stream && (2'(s) < r_cnt[r_col])) ? r_slot[r_col][s] : 7'd0;
    end
endmodule

// File: tb/tb_weight_comp_collector.sv
// tb_weight_comp_collector: randomized load/stream traffic checked by a queue scoreboard
// fed from an array-and-queue model of the collector.
module tb_weight_comp_collector;
    logic        clk = 1'b0;
    logic        rst, wt_valid, comp_valid, load_done, start, out_ready;
    logic [5:0]  wt_addr;
    logic [4:0]  reduced_wt;
    logic [2:0]  comp_row, comp_wt;
    logic        out_valid, ready_flag, overflow;
    logic [2:0]  out_col;
    logic [39:0] out_wts;
    logic [20:0] out_comp;

    always #5 clk = ~clk;

    weight_comp_collector #(.SIZE(8)) dut (
        .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_addr(wt_addr), .reduced_wt(reduced_wt),
        .comp_valid(comp_valid), .comp_row(comp_row), .comp_wt(comp_wt), .load_done(load_done),
        .start(start), .out_ready(out_ready), .out_valid(out_valid), .out_col(out_col),
        .out_wts(out_wts), .out_comp(out_comp), .ready_flag(ready_flag), .overflow(overflow)
    );

    typedef struct packed {
        logic [2:0]  col;
        logic [39:0] wts;
        logic [20:0] comp;
    } beat_t;

    beat_t      exp_q[$];
    int         tests = 0;
    int         errors = 0;
    logic [4:0] m_store [64];
    logic [5:0] m_comp [8][$];
    bit         m_ovf;
    int         m_phase;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int a = 0; a < 64; a++) m_store[a] = '0;
        for (int c = 0; c < 8; c++) m_comp[c].delete();
        m_ovf = 0;
        m_phase = 0;
        exp_q.delete();
    endtask

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_beat: got col %0d expected no beat", out_col);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_col", 64'(out_col), 64'(e.col));
                    check("beat_wts", 64'(out_wts), 64'(e.wts));
                    check("beat_comp", 64'(out_comp), 64'(e.comp));
                end
            end
        end
    end

    task automatic beat(input logic [5:0] a, input logic [4:0] w, input logic cv,
                        input logic [2:0] cr, input logic [2:0] cw, input logic ld);
        wt_valid = 1; wt_addr = a; reduced_wt = w;
        comp_valid = cv; comp_row = cr; comp_wt = cw; load_done = ld;
        if (m_phase == 0) begin
            m_store[a] = w;
            if (cv) begin
                if (m_comp[a[5:3]].size() < 3) m_comp[a[5:3]].push_back({cr, cw});
                else m_ovf = 1;
            end
            if (ld) m_phase = 1;
        end
        @(posedge clk); #1;
        wt_valid = 0; comp_valid = 0; load_done = 0;
    endtask

    task automatic comp_only(input logic [2:0] cr, input logic [2:0] cw);
        comp_valid = 1; comp_row = cr; comp_wt = cw; wt_addr = 6'($urandom);
        @(posedge clk); #1;
        comp_valid = 0;
    endtask

    task automatic finish_load();
        load_done = 1;
        if (m_phase == 0) m_phase = 1;
        @(posedge clk); #1;
        load_done = 0;
    endtask

    task automatic do_stream(input int mode, input int abort_col);
        beat_t       e;
        logic [63:0] snap;
        int          held;
        int          cyc;
        held = 0;
        cyc = 0;
        snap = '0;
        check("ready_flag_before_start", 64'(ready_flag), 64'd1);
        for (int c = 0; c < 8; c++) begin
            e.col = 3'(c);
            for (int r = 0; r < 8; r++) e.wts[5*r +: 5] = m_store[c*8 + r];
            for (int s = 0; s < 3; s++)
                e.comp[7*s +: 7] = (s < m_comp[c].size()) ? {1'b1, m_comp[c][s]} : 7'd0;
            exp_q.push_back(e);
        end
        m_phase = 2;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("valid_after_start", {61'd0, out_valid, out_col}, 64'h8);
        while (exp_q.size() > 0 && cyc < 200) begin
            if (abort_col >= 0 && int'(out_col) == abort_col) begin
                out_ready = 0;
                rst = 1;
                #1;
                check("abort_valid", 64'(out_valid), 64'd0);
                check("abort_overflow", 64'(overflow), 64'd0);
                check("abort_outputs", {22'd0, ready_flag, out_col, out_wts}, 64'd0);
                m_reset();
                #2;
                rst = 0;
                @(posedge clk); #1;
                return;
            end
            if (mode == 2 && out_col == 3'd4 && held < 5) begin
                if (held == 0) snap = {out_col, out_wts, out_comp};
                else check("hold_stable", {out_col, out_wts, out_comp}, snap);
                check("hold_col", 64'(out_col), 64'd4);
                out_ready = 0;
                held++;
            end else begin
                out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 0;
        if (exp_q.size() > 0) begin
            tests++;
            errors++;
            $display("FAIL stream_timeout: got %0d beats pending expected 0", exp_q.size());
            exp_q.delete();
        end
        m_phase = 0;
        for (int c = 0; c < 8; c++) m_comp[c].delete();
        check("back_in_load", {62'd0, out_valid, ready_flag}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; wt_valid = 0; wt_addr = '0; reduced_wt = '0; comp_valid = 0;
        comp_row = '0; comp_wt = '0; load_done = 0; start = 0; out_ready = 0;
        m_reset();
        #12;
        check("reset_flags", {61'd0, out_valid, ready_flag, overflow}, 64'd0);
        check("reset_data", {out_col, out_wts, out_comp}, 64'd0);
        rst = 0;
        @(posedge clk); #1;

        for (int a = 0; a < 64; a++) beat(6'(a), 5'(a), 0, 3'd0, 3'd0, a == 63);
        do_stream(0, -1);

        for (int r = 1; r < 8; r += 2) beat({3'd2, 3'(r)}, 5'($urandom), 1, 3'(r), 3'b101, 0);
        check("overflow_set", 64'(overflow), 64'd1);
        comp_only(3'd6, 3'd2);
        finish_load();
        do_stream(1, -1);

        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("start_in_load", {62'd0, out_valid, ready_flag}, 64'd0);
        finish_load();
        do_stream(0, -1);

        finish_load();
        beat(6'd0, 5'h1F, 1, 3'd1, 3'd1, 0);
        do_stream(2, -1);

        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(5, 40);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) comp_only(3'($urandom), 3'($urandom));
                beat(6'($urandom), 5'($urandom), 1'($urandom_range(0, 2) == 0),
                     3'($urandom), 3'($urandom), i == n - 1);
            end
            check("overflow_model", 64'(overflow), 64'(m_ovf));
            do_stream(k % 3, -1);
        end

        for (int i = 0; i < 4; i++) beat({3'd5, 3'(i)}, 5'($urandom), 1, 3'(i), 3'd3, 0);
        finish_load();
        check("overflow_before_abort", 64'(overflow), 64'd1);
        do_stream(0, 3);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("no_beat_after_abort", 64'(out_valid), 64'd0);
        finish_load();
        do_stream(0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
